// File: rtl/sw_event_pkg.sv
// Shared types and constants for the slide-switch PIO event sequencer.
package sw_event_pkg;

  typedef enum logic [3:0] {
    ST_RST,
    ST_INIT_MASK,
    ST_INIT_CLR,
    ST_IDLE,
    ST_CAP_REQ,
    ST_CAP_CLR,
    ST_LVL_REQ,
    ST_LVL_LAT,
    ST_PUSH
  } sw_seq_state_t;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int unsigned SW_WIDTH = 10;

  typedef struct packed {
    logic [SW_WIDTH-1:0] capture;
    logic [SW_WIDTH-1:0] level;
  } sw_event_t;

endpackage

// File: rtl/sw_event_fifo.sv
// First-word-fall-through FIFO; a pop frees its slot for a push in the same cycle.
module sw_event_fifo #(
  parameter int unsigned DW    = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          rd_en_i,
  output logic [DW-1:0] rd_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             push, pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == DEPTH_CNT);
  assign pop       = rd_en_i && !empty_o;
  assign push      = wr_en_i && (!full_o || pop);
  // Head reads as zero when empty so the event outputs are clean after reset.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sw_event_sequencer.sv
// Owns the slide-switch PIO: programs its IRQ mask, services each interrupt by
// reading capture and level, and queues {capture, level} events for a consumer.
module sw_event_sequencer
  import sw_event_pkg::*;
#(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             irq_in,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic [WIDTH-1:0] cfg_mask,
  input  logic             cfg_load,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_capture,
  output logic [WIDTH-1:0] evt_level,
  output logic             evt_overflow,
  input  logic             ovf_clr,
  output logic             busy
);

  sw_seq_state_t     state_q, state_d;
  logic              cs_q, wr_n_q, busy_q, ovf_q;
  logic [1:0]        addr_q;
  logic [31:0]       wdata_q;
  logic [WIDTH-1:0]  cap_q, lvl_q;
  logic              push_req, fifo_full, fifo_empty, drop;
  logic [2*WIDTH-1:0] head;
  logic              unused_rd;

  assign unused_rd = ^pio_readdata;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RST:       state_d = ST_INIT_MASK;
      ST_INIT_MASK: state_d = ST_INIT_CLR;
      ST_INIT_CLR:  state_d = ST_IDLE;
      ST_IDLE: begin
        if (cfg_load)    state_d = ST_INIT_MASK;
        else if (irq_in) state_d = ST_CAP_REQ;
      end
      ST_CAP_REQ:   state_d = ST_CAP_CLR;
      ST_CAP_CLR:   state_d = ST_LVL_REQ;
      ST_LVL_REQ:   state_d = ST_LVL_LAT;
      ST_LVL_LAT:   state_d = ST_PUSH;
      ST_PUSH:      state_d = ST_IDLE;
      default:      state_d = ST_RST;
    endcase
  end

  // A capture of zero means the interrupt raced a clear; nothing to report.
  assign push_req = (state_q == ST_PUSH) && (cap_q != '0);
  assign drop     = push_req && fifo_full && !(evt_valid && evt_ready);

  // Bus outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      addr_q  <= PIO_ADDR_DATA;
      wdata_q <= '0;
      busy_q  <= 1'b1;
      cap_q   <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      cs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      addr_q  <= PIO_ADDR_DATA;
      wdata_q <= '0;
      case (state_d)
        ST_INIT_MASK: begin
          cs_q    <= 1'b1;
          wr_n_q  <= 1'b0;
          addr_q  <= PIO_ADDR_MASK;
          wdata_q <= 32'(cfg_mask);
        end
        ST_INIT_CLR, ST_CAP_CLR: begin
          cs_q   <= 1'b1;
          wr_n_q <= 1'b0;
          addr_q <= PIO_ADDR_EDGE;
        end
        ST_CAP_REQ: begin
          cs_q   <= 1'b1;
          addr_q <= PIO_ADDR_EDGE;
        end
        ST_LVL_REQ: begin
          cs_q   <= 1'b1;
          addr_q <= PIO_ADDR_DATA;
        end
        default: ;
      endcase
      if (state_q == ST_CAP_CLR) cap_q <= pio_readdata[WIDTH-1:0];
      if (state_q == ST_LVL_LAT) lvl_q <= pio_readdata[WIDTH-1:0];
      if (drop)         ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
    end
  end

  sw_event_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push_req),
    .wr_data_i ({cap_q, lvl_q}),
    .rd_en_i   (evt_ready),
    .rd_data_o (head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign pio_chipselect = cs_q;
  assign pio_write_n    = wr_n_q;
  assign pio_address    = addr_q;
  assign pio_writedata  = wdata_q;
  assign busy           = busy_q;
  assign evt_overflow   = ovf_q;
  assign evt_valid      = !fifo_empty;
  assign evt_capture    = head[2*WIDTH-1:WIDTH];
  assign evt_level      = head[WIDTH-1:0];

endmodule

// File: tb/tb_sw_event_sequencer.sv
// Bench for sw_event_sequencer: behavioural slide-switch PIO plus an event
// scoreboard filled when switch edges are driven and drained from the FIFO port.
module tb_sw_event_sequencer;
  import sw_event_pkg::*;

  localparam int W = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          irq_in;
  logic [1:0]    pio_address;
  logic          pio_chipselect, pio_write_n;
  logic [31:0]   pio_writedata, pio_readdata;
  logic [W-1:0]  cfg_mask;
  logic          cfg_load;
  logic          evt_valid, evt_ready;
  logic [W-1:0]  evt_capture, evt_level;
  logic          evt_overflow, ovf_clr, busy;

  logic [W-1:0]  sw, sw_prev, pio_edge, pio_mask;
  logic [35:0]   bus;
  sw_event_t     sb[$];
  int            n_checks = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  sw_event_sequencer #(.WIDTH(W), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq_in         (irq_in),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata),
    .pio_readdata   (pio_readdata),
    .cfg_mask       (cfg_mask),
    .cfg_load       (cfg_load),
    .evt_valid      (evt_valid),
    .evt_ready      (evt_ready),
    .evt_capture    (evt_capture),
    .evt_level      (evt_level),
    .evt_overflow   (evt_overflow),
    .ovf_clr        (ovf_clr),
    .busy           (busy)
  );

  // PIO: rising-edge capture, clear-all on write to 3 (clear beats a new edge),
  // registered readdata, combinational irq.
  always @(posedge clk) begin
    sw_prev <= sw;
    if (reset) begin
      pio_edge     <= '0;
      pio_mask     <= '0;
      pio_readdata <= '0;
    end else begin
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) pio_edge <= '0;
      else pio_edge <= pio_edge | (sw & ~sw_prev);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pio_mask <= pio_writedata[W-1:0];
      case (pio_address)
        2'd0:    pio_readdata <= 32'(sw);
        2'd2:    pio_readdata <= 32'(pio_mask);
        2'd3:    pio_readdata <= 32'(pio_edge);
        default: pio_readdata <= '0;
      endcase
    end
  end

  assign irq_in = |(pio_edge & pio_mask);
  assign bus    = {pio_chipselect, pio_write_n, pio_address, pio_writedata};

  task automatic inject(input int b, input bit expect_evt);
    sw_event_t e;
    logic [W-1:0] m;
    int n;
    @(negedge clk);
    m = '0;
    m[b] = 1'b1;
    sw = sw | m;
    e.capture = m;
    e.level   = sw;
    if (expect_evt) sb.push_back(e);
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    while (busy && n < 30) begin @(negedge clk); n++; end
    n_checks++;
    if (n >= 30 || (n >= 10 && !busy && n < 11)) begin
      $display("FAIL inject_timeout bit=%0d cycles=%0d busy=%b required service within bound", b, n, busy);
      n_fail++;
    end
  endtask

  task automatic drain_one(input string name);
    sw_event_t exp;
    int n;
    n = 0;
    while (!evt_valid && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (!evt_valid || sb.size() == 0) begin
      $display("FAIL %s_valid evt_valid=%b pending=%0d required 1 and pending>0", name, evt_valid, sb.size());
      n_fail++;
    end else begin
      exp = sb.pop_front();
      if ({evt_capture, evt_level} !== exp) begin
        $display("FAIL %s_head got cap=%h lvl=%h required cap=%h lvl=%h", name, evt_capture, evt_level, exp.capture, exp.level);
        n_fail++;
      end
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
    end
  endtask

  task automatic wait_cap_clr(output bit found);
    int n;
    n = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      @(negedge clk);
      n++;
      found = busy && pio_chipselect && !pio_write_n && pio_address == 2'd3;
    end
    n_checks++;
    if (!found) begin
      $display("FAIL cap_clr_timeout cycles=%0d required capture-clear write within 20", n);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    cfg_mask = 10'h3FF;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus, busy} !== {1'b0, 1'b1, 2'd0, 32'h0, 1'b1}) begin
      $display("FAIL reset_bus got bus=%h busy=%b required bus=%h busy=1", bus, busy, {1'b0, 1'b1, 2'd0, 32'h0});
      n_fail++;
    end
    n_checks++;
    if ({evt_valid, evt_capture, evt_level, evt_overflow} !== '0) begin
      $display("FAIL reset_evt got v=%b cap=%h lvl=%h ovf=%b required all 0", evt_valid, evt_capture, evt_level, evt_overflow);
      n_fail++;
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus, busy} !== {1'b1, 1'b0, 2'd2, 32'h3FF, 1'b1}) begin
      $display("FAIL init_mask got bus=%h busy=%b required bus=%h busy=1", bus, busy, {1'b1, 1'b0, 2'd2, 32'h3FF});
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if ({bus, busy} !== {1'b1, 1'b0, 2'd3, 32'h0, 1'b1}) begin
      $display("FAIL init_clr got bus=%h busy=%b required bus=%h busy=1", bus, busy, {1'b1, 1'b0, 2'd3, 32'h0});
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if ({pio_chipselect, busy} !== 2'b00) begin
      $display("FAIL init_idle got cs=%b busy=%b required cs=0 busy=0", pio_chipselect, busy);
      n_fail++;
    end
  endtask

  task automatic test_single_event();
    sw_event_t e;
    int lat;
    @(negedge clk);
    sw[2] = 1'b1;
    e.capture = 10'h004;
    e.level   = 10'h004;
    sb.push_back(e);
    @(negedge clk);
    n_checks++;
    if ({irq_in, busy} !== 2'b10) begin
      $display("FAIL single_irq got irq=%b busy=%b required irq=1 busy=0", irq_in, busy);
      n_fail++;
    end
    lat = 0;
    while (!evt_valid && lat < 20) begin @(negedge clk); lat++; end
    n_checks++;
    if (lat != 6) begin
      $display("FAIL single_latency got %0d cycles required 6", lat);
      n_fail++;
    end
    n_checks++;
    if ({irq_in, busy} !== 2'b00) begin
      $display("FAIL single_after got irq=%b busy=%b required irq=0 busy=0", irq_in, busy);
      n_fail++;
    end
    drain_one("single");
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    @(negedge clk);
    sw = '0;
    for (int k = 0; k < 5; k++) inject(k, sb.size() < 4);
    n_checks++;
    if (evt_overflow !== 1'b1) begin
      $display("FAIL ovf_set got %b required 1", evt_overflow);
      n_fail++;
    end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++;
    if (evt_overflow !== 1'b0) begin
      $display("FAIL ovf_clr got %b required 0", evt_overflow);
      n_fail++;
    end
    for (int k = 0; k < 4; k++) drain_one("ovf_drain");
    n_checks++;
    if (evt_valid !== 1'b0) begin
      $display("FAIL ovf_empty got evt_valid=%b required 0", evt_valid);
      n_fail++;
    end
  endtask

  task automatic test_cfg_irq_priority();
    @(negedge clk);
    sw = '0;
    @(negedge clk);
    sw[7] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({irq_in, busy} !== 2'b10) begin
      $display("FAIL prio_irq got irq=%b busy=%b required irq=1 busy=0", irq_in, busy);
      n_fail++;
    end
    cfg_mask = 10'h1FF;
    cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    n_checks++;
    if (bus !== {1'b1, 1'b0, 2'd2, 32'h1FF}) begin
      $display("FAIL prio_mask_first got bus=%h required %h", bus, {1'b1, 1'b0, 2'd2, 32'h1FF});
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (bus !== {1'b1, 1'b0, 2'd3, 32'h0}) begin
      $display("FAIL prio_clr got bus=%h required %h", bus, {1'b1, 1'b0, 2'd3, 32'h0});
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      $display("FAIL prio_idle got busy=%b required 0", busy);
      n_fail++;
    end
    // The edge pending at reload is cleared with the capture; service resumes
    // under the new mask for the next edge.
    inject(8, 1'b1);
    drain_one("prio");
  endtask

  task automatic test_push_pop_full();
    sw_event_t e;
    bit found;
    evt_ready = 1'b0;
    @(negedge clk);
    sw = '0;
    for (int k = 0; k < 4; k++) inject(k, 1'b1);
    @(negedge clk);
    sw[5] = 1'b1;
    e.capture = 10'h020;
    e.level   = sw;
    sb.push_back(e);
    wait_cap_clr(found);
    if (found) begin
      repeat (3) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({evt_valid, evt_capture, evt_level} !== {1'b1, e}) begin
        $display("FAIL pp_head got v=%b cap=%h lvl=%h required v=1 cap=%h lvl=%h", evt_valid, evt_capture, evt_level, e.capture, e.level);
        n_fail++;
      end
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      n_checks++;
      if ({evt_overflow, busy} !== 2'b00) begin
        $display("FAIL pp_no_drop got ovf=%b busy=%b required ovf=0 busy=0", evt_overflow, busy);
        n_fail++;
      end
      for (int k = 0; k < 4; k++) drain_one("pp_drain");
      n_checks++;
      if (evt_valid !== 1'b0) begin
        $display("FAIL pp_empty got evt_valid=%b required 0", evt_valid);
        n_fail++;
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    evt_ready = 1'b0;
    @(negedge clk);
    sw = '0;
    inject(4, 1'b1);
    inject(5, 1'b1);
    @(negedge clk);
    sw[6] = 1'b1;
    wait_cap_clr(found);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    n_checks++;
    if ({bus, evt_valid, evt_overflow, busy} !== {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      $display("FAIL mid_reset got bus=%h v=%b ovf=%b busy=%b required idle bus v=0 ovf=0 busy=1", bus, evt_valid, evt_overflow, busy);
      n_fail++;
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus !== {1'b1, 1'b0, 2'd2, 32'h1FF}) begin
      $display("FAIL mid_init_mask got bus=%h required %h", bus, {1'b1, 1'b0, 2'd2, 32'h1FF});
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if (bus !== {1'b1, 1'b0, 2'd3, 32'h0}) begin
      $display("FAIL mid_init_clr got bus=%h required %h", bus, {1'b1, 1'b0, 2'd3, 32'h0});
      n_fail++;
    end
    @(negedge clk);
    n_checks++;
    if ({busy, evt_valid} !== 2'b00) begin
      $display("FAIL mid_idle got busy=%b v=%b required busy=0 v=0", busy, evt_valid);
      n_fail++;
    end
  endtask

  initial begin
    sw        = '0;
    cfg_mask  = '0;
    cfg_load  = 1'b0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    reset     = 1'b1;
    test_reset();
    test_single_event();
    test_overflow();
    test_cfg_irq_priority();
    test_push_pop_full();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
